gray_counter_n: RTL and testbench

Parametrised Gray-code counter generalising the team's fixed 3-bit Gray counter to any width.
- Adds up/down counting, synchronous parallel load and selectable wrap/saturate mode.
- Overflow and Underflow are separate sticky flags with an explicit clear; Wrap is a one-cycle pulse on each boundary event.
- Outputs come from state registers only, so the block can drive clock-domain-crossing pointers and position encoders directly.

---
 rtl/gray_counter_n.sv | 92 +++++++++
 tb/tb_gray_counter_n.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - parametrised up/down Gray counter with load, wrap/saturate and sticky boundary flags
module gray_counter_n #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wrp_q, wrp_d;
    logic [WIDTH-1:0] load_bin;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        load_bin = gray_to_bin(LoadValue);
        cnt_d    = cnt_q;
        ovf_d    = ovf_q & ~ClrFlags;
        unf_d    = unf_q & ~ClrFlags;
        wrp_d    = 1'b0;
        if (Load) begin
            cnt_d = load_bin;
        end else if (En) begin
            if (Dir) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = SATURATE ? CNT_MAX : CNT_MIN;
                    ovf_d = 1'b1;
                    wrp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == CNT_MIN) begin
                    cnt_d = SATURATE ? CNT_MIN : CNT_MAX;
                    unf_d = 1'b1;
                    wrp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
        // Gray value is registered alongside the binary so Output is a clean flop for CDC use
        gray_d = cnt_d ^ (cnt_d >> 1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            wrp_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            wrp_q  <= wrp_d;
        end
    end

    assign Output    = gray_q;
    assign Binary    = cnt_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign Wrap      = wrp_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - self-checking bench for gray_counter_n at widths 3, 4 (saturate) and 8
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=3 wrap instance
    logic       r3 = 1'b0, e3 = 1'b0, d3 = 1'b0, l3 = 1'b0, c3 = 1'b0;
    logic [2:0] lv3 = '0;
    logic [2:0] o3, b3;
    logic       ov3, un3, w3;

    // WIDTH=4 saturate instance
    logic       r4 = 1'b0, e4 = 1'b0, d4 = 1'b0, l4 = 1'b0, c4 = 1'b0;
    logic [3:0] lv4 = '0;
    logic [3:0] o4, b4;
    logic       ov4, un4, w4;

    // WIDTH=8 wrap instance
    logic       r8 = 1'b0, e8 = 1'b0, d8 = 1'b0, l8 = 1'b0, c8 = 1'b0;
    logic [7:0] lv8 = '0;
    logic [7:0] o8, b8;
    logic       ov8, un8, w8;

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u3 (
        .Clk(clk), .Reset(r3), .En(e3), .Dir(d3), .Load(l3), .LoadValue(lv3), .ClrFlags(c3),
        .Output(o3), .Binary(b3), .Overflow(ov3), .Underflow(un3), .Wrap(w3));

    gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) u4 (
        .Clk(clk), .Reset(r4), .En(e4), .Dir(d4), .Load(l4), .LoadValue(lv4), .ClrFlags(c4),
        .Output(o4), .Binary(b4), .Overflow(ov4), .Underflow(un4), .Wrap(w4));

    gray_counter_n #(.WIDTH(8), .SATURATE(1'b0)) u8 (
        .Clk(clk), .Reset(r8), .En(e8), .Dir(d8), .Load(l8), .LoadValue(lv8), .ClrFlags(c8),
        .Output(o8), .Binary(b8), .Overflow(ov8), .Underflow(un8), .Wrap(w8));

    typedef struct {
        logic       rst, en, dir, ld;
        logic [2:0] lv;
        logic       clr;
        logic [2:0] out, bin;
        logic       ovf, unf, wrp;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, en, dir, ld, input logic [2:0] lv, input logic clr,
                       input logic [2:0] out, bin, input logic ovf, unf, wrp);
        vec_t v;
        v.rst = rst; v.en = en; v.dir = dir; v.ld = ld; v.lv = lv; v.clr = clr;
        v.out = out; v.bin = bin; v.ovf = ovf; v.unf = unf; v.wrp = wrp;
        tbl.push_back(v);
    endtask

    function automatic logic [7:0] decode8(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic step4(input logic rst, en, dir, ld, input logic [3:0] lv);
        @(negedge clk);
        r4 = rst; e4 = en; d4 = dir; l4 = ld; lv4 = lv; c4 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst en dir ld lv      clr  out     bin  ovf unf wrp
        add(1, 0, 0, 0, 3'b000, 0, 3'b000, 3'd0, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b001, 3'd1, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b011, 3'd2, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b010, 3'd3, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b110, 3'd4, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b111, 3'd5, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b101, 3'd6, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b100, 3'd7, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b000, 3'd0, 1, 0, 1);
        add(0, 1, 1, 0, 3'b000, 0, 3'b001, 3'd1, 1, 0, 0);
        add(0, 0, 1, 0, 3'b000, 0, 3'b001, 3'd1, 1, 0, 0);
        add(0, 0, 0, 0, 3'b000, 1, 3'b001, 3'd1, 0, 0, 0);
        add(0, 0, 0, 1, 3'b100, 0, 3'b100, 3'd7, 0, 0, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b000, 3'd0, 1, 0, 1);
        add(0, 0, 0, 1, 3'b100, 0, 3'b100, 3'd7, 1, 0, 0);
        add(0, 1, 1, 0, 3'b000, 1, 3'b000, 3'd0, 1, 0, 1);
        add(0, 0, 0, 0, 3'b000, 1, 3'b000, 3'd0, 0, 0, 0);
        add(1, 1, 1, 0, 3'b000, 0, 3'b000, 3'd0, 0, 0, 0);
        add(0, 1, 0, 0, 3'b000, 0, 3'b100, 3'd7, 0, 1, 1);
        add(0, 1, 0, 0, 3'b000, 0, 3'b101, 3'd6, 0, 1, 0);
        add(0, 1, 0, 1, 3'b110, 0, 3'b110, 3'd4, 0, 1, 0);
        add(0, 1, 0, 0, 3'b000, 0, 3'b010, 3'd3, 0, 1, 0);
        add(0, 1, 1, 0, 3'b000, 0, 3'b110, 3'd4, 0, 1, 0);
        add(1, 1, 1, 1, 3'b111, 0, 3'b000, 3'd0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            r3 = tbl[i].rst; e3 = tbl[i].en; d3 = tbl[i].dir; l3 = tbl[i].ld;
            lv3 = tbl[i].lv; c3 = tbl[i].clr;
            @(posedge clk);
            #1;
            chk("w3_output", i, 32'(o3), 32'(tbl[i].out));
            chk("w3_binary", i, 32'(b3), 32'(tbl[i].bin));
            chk("w3_overflow", i, 32'(ov3), 32'(tbl[i].ovf));
            chk("w3_underflow", i, 32'(un3), 32'(tbl[i].unf));
            chk("w3_wrap", i, 32'(w3), 32'(tbl[i].wrp));
        end
        @(negedge clk);
        r3 = 1'b0; e3 = 1'b0; l3 = 1'b0; c3 = 1'b0;

        // Saturate mode: hold at max while re-flagging every enabled step
        step4(1, 0, 0, 0, 4'b0000);
        chk("w4_reset_out", 0, 32'(o4), 32'h0);
        step4(0, 0, 0, 1, 4'b1000);
        chk("w4_load_bin", 0, 32'(b4), 32'd15);
        chk("w4_load_wrap", 0, 32'(w4), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step4(0, 1, 1, 0, 4'b0000);
            chk("w4_sat_out", k, 32'(o4), 32'b1000);
            chk("w4_sat_bin", k, 32'(b4), 32'd15);
            chk("w4_sat_ovf", k, 32'(ov4), 32'h1);
            chk("w4_sat_wrap", k, 32'(w4), 32'h1);
        end
        step4(0, 1, 0, 0, 4'b0000);
        chk("w4_rev_out", 0, 32'(o4), 32'b1001);
        chk("w4_rev_wrap", 0, 32'(w4), 32'h0);
        chk("w4_rev_ovf", 0, 32'(ov4), 32'h1);
        step4(1, 0, 0, 0, 4'b0000);
        step4(0, 1, 0, 0, 4'b0000);
        chk("w4_sat0_out", 0, 32'(o4), 32'h0);
        chk("w4_sat0_unf", 0, 32'(un4), 32'h1);
        chk("w4_sat0_wrap", 0, 32'(w4), 32'h1);
        chk("w4_sat0_ovf", 0, 32'(ov4), 32'h0);
        step4(0, 0, 0, 0, 4'b0000);
        chk("w4_wrap_drop", 0, 32'(w4), 32'h0);

        // Randomised run at WIDTH=8 against a behavioural model
        begin
            logic [7:0] m_cnt, prev_out;
            logic       m_ovf, m_unf, m_wrp;
            logic       rst, en, dir, ld, clr;
            logic [7:0] lv;
            m_cnt = '0; m_ovf = 1'b0; m_unf = 1'b0; m_wrp = 1'b0; prev_out = '0;
            for (int n = 0; n < 10000 && errors < 50; n++) begin
                rst = (n == 0) || (n == 5000) || ($urandom_range(0, 499) == 0);
                en  = ($urandom_range(0, 3) != 0);
                dir = $urandom_range(0, 1);
                ld  = ($urandom_range(0, 15) == 0);
                clr = ($urandom_range(0, 31) == 0);
                lv  = 8'($urandom);
                if (n % 97 == 0) lv = 8'h80;
                @(negedge clk);
                r8 = rst; e8 = en; d8 = dir; l8 = ld; lv8 = lv; c8 = clr;
                if (clr) begin
                    m_ovf = 1'b0;
                    m_unf = 1'b0;
                end
                m_wrp = 1'b0;
                if (rst) begin
                    m_cnt = '0; m_ovf = 1'b0; m_unf = 1'b0;
                end else if (ld) begin
                    m_cnt = decode8(lv);
                end else if (en && dir) begin
                    if (m_cnt == 8'd255) begin m_ovf = 1'b1; m_wrp = 1'b1; end
                    m_cnt = m_cnt + 8'd1;
                end else if (en) begin
                    if (m_cnt == 8'd0) begin m_unf = 1'b1; m_wrp = 1'b1; end
                    m_cnt = m_cnt - 8'd1;
                end
                @(posedge clk);
                #1;
                chk("w8_binary", n, 32'(b8), 32'(m_cnt));
                chk("w8_output", n, 32'(o8), 32'(m_cnt ^ (m_cnt >> 1)));
                chk("w8_decode", n, 32'(decode8(o8)), 32'(b8));
                chk("w8_flags", n, {29'd0, ov8, un8, w8}, {29'd0, m_ovf, m_unf, m_wrp});
                if (!rst && !ld && en)
                    chk("w8_onebit", n, 32'($countones(prev_out ^ o8)), 32'd1);
                if (rst)
                    chk("w8_reset_zero", n, {14'd0, o8, b8, ov8, un8}, 32'h0);
                prev_out = o8;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
